// File: rtl/instruction_fetch_stage.sv
// ============================================================================
// Module      : instruction_fetch_stage
// Description : IF stage of the 5-stage MIPS pipeline. Owns the program
//               counter, drives the byte address into instruction memory and
//               captures the returned word into the IF/ID pipeline register.
//               Handles stalls, redirects (with squash), fetch enable and
//               address wrap within MEM_BYTES.
//               Optional macro FETCH_MISALIGN_CHECK_EN adds a sticky
//               fetch_fault output raised by a misaligned redirect target,
//               after which fetch is frozen until reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instruction_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_en,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic [31:0] inst_addr,
    input  logic [31:0] inst_in,
    output logic [31:0] if_id_inst,
    output logic [31:0] if_id_pc_plus4,
    output logic        if_id_valid,
`ifdef FETCH_MISALIGN_CHECK_EN
    output logic        fetch_fault,
`endif
    output logic [31:0] pc_out
);

    // Keeps PC arithmetic inside the instruction memory window.
    localparam logic [31:0] c_ADDR_MASK = 32'(MEM_BYTES - 1);
    // Word-aligned form of the window mask.
    localparam logic [31:0] c_WORD_MASK = c_ADDR_MASK & ~32'h3;

    logic [31:0] r_pc;
    logic [31:0] r_if_id_inst;
    logic [31:0] r_if_id_pc_plus4;
    logic        r_if_id_valid;

    logic [31:0] w_seq_pc;
    logic [31:0] w_redirect_pc;
    logic        w_redirect;
    logic        w_fetch_go;

    // Sequential and redirect addresses, both wrapped and word aligned.
    always_comb begin
        w_seq_pc      = (r_pc + 32'd4) & c_WORD_MASK;
        w_redirect_pc = redirect_target & c_WORD_MASK;
    end

`ifdef FETCH_MISALIGN_CHECK_EN
    logic r_fault;

    // Once faulted, redirects are ignored and fetch behaves as disabled.
    always_comb begin
        w_redirect = redirect_valid & ~r_fault;
        w_fetch_go = fetch_en & ~r_fault;
    end

    // Sticky fault on any accepted redirect whose target is not word aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fault <= 1'b0;
        end else if (w_redirect && (redirect_target[1:0] != 2'b00)) begin
            r_fault <= 1'b1;
        end
    end

    assign fetch_fault = r_fault;
`else
    // Without the fault check every redirect and fetch enable is honoured.
    always_comb begin
        w_redirect = redirect_valid;
        w_fetch_go = fetch_en;
    end
`endif

    // PC and IF/ID register update: redirect beats stall beats fetch enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc             <= RESET_PC;
            r_if_id_inst     <= 32'h0;
            r_if_id_pc_plus4 <= 32'h0;
            r_if_id_valid    <= 1'b0;
        end else if (w_redirect) begin
            // Squash the wrong-path word fetched this cycle.
            r_pc             <= w_redirect_pc;
            r_if_id_inst     <= 32'h0;
            r_if_id_pc_plus4 <= 32'h0;
            r_if_id_valid    <= 1'b0;
        end else if (stall) begin
            r_pc             <= r_pc;
            r_if_id_inst     <= r_if_id_inst;
            r_if_id_pc_plus4 <= r_if_id_pc_plus4;
            r_if_id_valid    <= r_if_id_valid;
        end else if (!w_fetch_go) begin
            // Bubble: all-zero word decodes as a NOP.
            r_pc             <= r_pc;
            r_if_id_inst     <= 32'h0;
            r_if_id_pc_plus4 <= 32'h0;
            r_if_id_valid    <= 1'b0;
        end else begin
            r_pc             <= w_seq_pc;
            r_if_id_inst     <= inst_in;
            r_if_id_pc_plus4 <= w_seq_pc;
            r_if_id_valid    <= 1'b1;
        end
    end

    assign inst_addr      = r_pc;
    assign pc_out         = r_pc;
    assign if_id_inst     = r_if_id_inst;
    assign if_id_pc_plus4 = r_if_id_pc_plus4;
    assign if_id_valid    = r_if_id_valid;

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch_stage.sv
// ============================================================================
// Module      : tb_instruction_fetch_stage
// Description : Directed self-checking bench for instruction_fetch_stage.
//               Memory word at byte address A holds 32'hC0DE_0000 | A.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instruction_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        fetch_en;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic [31:0] inst_addr;
    logic [31:0] inst_in;
    logic [31:0] if_id_inst;
    logic [31:0] if_id_pc_plus4;
    logic        if_id_valid;
    logic [31:0] pc_out;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        fetch_fault;
`endif

    logic [31:0] r_mem [0:255];

    int n_checks = 0;
    int n_fail   = 0;

    instruction_fetch_stage #(
        .RESET_PC  (32'h0000_0000),
        .MEM_BYTES (1024)
    ) u_dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .fetch_en        (fetch_en),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .inst_addr       (inst_addr),
        .inst_in         (inst_in),
        .if_id_inst      (if_id_inst),
        .if_id_pc_plus4  (if_id_pc_plus4),
        .if_id_valid     (if_id_valid),
`ifdef FETCH_MISALIGN_CHECK_EN
        .fetch_fault     (fetch_fault),
`endif
        .pc_out          (pc_out)
    );

    // Combinational instruction memory.
    assign inst_in = r_mem[inst_addr[9:2]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) r_mem[i] = 32'hC0DE_0000 | (i << 2);

        rst_n           = 1'b0;
        fetch_en        = 1'b1;
        stall           = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 32'h0;

        // Reset state
        step(); step();
        chk("rst_pc",    pc_out, 32'h0);
        chk("rst_addr",  inst_addr, 32'h0);
        chk("rst_inst",  if_id_inst, 32'h0);
        chk("rst_p4",    if_id_pc_plus4, 32'h0);
        chk("rst_valid", {31'b0, if_id_valid}, 32'h0);
        rst_n = 1'b1;

        // Straight-line fetch
        step();
        chk("f0_inst",  if_id_inst, 32'hC0DE_0000);
        chk("f0_p4",    if_id_pc_plus4, 32'h4);
        chk("f0_valid", {31'b0, if_id_valid}, 32'h1);
        chk("f0_pc",    pc_out, 32'h4);
        step();
        chk("f1_inst",  if_id_inst, 32'hC0DE_0004);
        chk("f1_p4",    if_id_pc_plus4, 32'h8);
        chk("f1_pc",    pc_out, 32'h8);

        // Stall for two edges with I1 in IF/ID
        stall = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step();
            chk("stall_inst",  if_id_inst, 32'hC0DE_0004);
            chk("stall_valid", {31'b0, if_id_valid}, 32'h1);
            chk("stall_pc",    pc_out, 32'h8);
        end
        stall = 1'b0;
        step();
        chk("rel_inst", if_id_inst, 32'hC0DE_0008);
        chk("rel_p4",   if_id_pc_plus4, 32'hC);
        chk("rel_pc",   pc_out, 32'hC);
        step();
        chk("f3_inst", if_id_inst, 32'hC0DE_000C);
        chk("f3_pc",   pc_out, 32'h10);

        // Fetch disabled at pc=0x10
        fetch_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("dis_pc",    pc_out, 32'h10);
            chk("dis_valid", {31'b0, if_id_valid}, 32'h0);
            chk("dis_inst",  if_id_inst, 32'h0);
        end
        fetch_en = 1'b1;
        step();
        chk("en_inst", if_id_inst, 32'hC0DE_0010);
        chk("en_p4",   if_id_pc_plus4, 32'h14);
        chk("en_pc",   pc_out, 32'h14);

        // Redirect wins over stall
        redirect_valid  = 1'b1;
        redirect_target = 32'h40;
        stall           = 1'b1;
        step();
        redirect_valid = 1'b0;
        stall          = 1'b0;
        chk("rd_pc",    pc_out, 32'h40);
        chk("rd_valid", {31'b0, if_id_valid}, 32'h0);
        chk("rd_inst",  if_id_inst, 32'h0);
        chk("rd_p4",    if_id_pc_plus4, 32'h0);
        step();
        chk("rd1_inst",  if_id_inst, 32'hC0DE_0040);
        chk("rd1_p4",    if_id_pc_plus4, 32'h44);
        chk("rd1_valid", {31'b0, if_id_valid}, 32'h1);

        // Wrap from last word of memory
        redirect_valid  = 1'b1;
        redirect_target = 32'h3FC;
        step();
        redirect_valid = 1'b0;
        chk("wr_pc", pc_out, 32'h3FC);
        step();
        chk("wr_inst", if_id_inst, 32'hC0DE_03FC);
        chk("wr_p4",   if_id_pc_plus4, 32'h0);
        chk("wr_pc0",  pc_out, 32'h0);

        // Upper target bits discarded
        redirect_valid  = 1'b1;
        redirect_target = 32'h404;
        step();
        chk("hi_pc", pc_out, 32'h4);
        redirect_target = 32'hFFFF_F81C;
        step();
        redirect_valid = 1'b0;
        chk("hi2_pc", pc_out, 32'h1C);
        step();
        chk("pre_rst_pc", pc_out, 32'h20);

        // Asynchronous reset mid-cycle while fetching at 0x20
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_pc",    pc_out, 32'h0);
        chk("arst_valid", {31'b0, if_id_valid}, 32'h0);
        chk("arst_inst",  if_id_inst, 32'h0);
        #2;
        rst_n = 1'b1;
        step();
        chk("post_rst_inst", if_id_inst, 32'hC0DE_0000);
        chk("post_rst_pc",   pc_out, 32'h4);

`ifdef FETCH_MISALIGN_CHECK_EN
        chk("flt_init", {31'b0, fetch_fault}, 32'h0);
        redirect_valid  = 1'b1;
        redirect_target = 32'h42;
        step();
        chk("flt_set", {31'b0, fetch_fault}, 32'h1);
        chk("flt_pc",  pc_out, 32'h40);
        redirect_target = 32'h80;
        step();
        redirect_valid = 1'b0;
        chk("flt_ign_pc", pc_out, 32'h40);
        step();
        chk("flt_valid", {31'b0, if_id_valid}, 32'h0);
        chk("flt_inst",  if_id_inst, 32'h0);
        chk("flt_pc2",   pc_out, 32'h40);
        chk("flt_stick", {31'b0, fetch_fault}, 32'h1);
`else
        // Misaligned target silently aligned, fetch continues
        redirect_valid  = 1'b1;
        redirect_target = 32'h43;
        step();
        redirect_valid = 1'b0;
        chk("mis_pc", pc_out, 32'h40);
        step();
        chk("mis_inst",  if_id_inst, 32'hC0DE_0040);
        chk("mis_valid", {31'b0, if_id_valid}, 32'h1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
